// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with enable, a latched
// select (direct mode) and a self-running prescaled scan sequencer.
//
// Build option: define SCAN_DECODER_BLANK_EN to blank the first cycle of each
// scan dwell (anti-ghosting for multiplexed displays).
//
// Ports:
//   CLK   in   rising-edge clock
//   RST_N in   asynchronous active-low reset
//   E     in   output enable
//   MODE  in   0 = direct, 1 = scan
//   A     in   [N-1:0] select value, captured on LOAD
//   LOAD  in   single-cycle strobe, IDX <= A
//   O     out  [2^N-1:0] registered one-hot output
//   IDX   out  [N-1:0] current registered index
//   WRAP  out  one-cycle pulse when the scan index wraps to 0
module scan_decoder #(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               E,
  input  logic               MODE,
  input  logic [N-1:0]       A,
  input  logic               LOAD,
  output logic [(1<<N)-1:0]  O,
  output logic [N-1:0]       IDX,
  output logic               WRAP
);

  localparam int W  = 1 << N;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } mode_e;

  mode_e          mode_q, mode_d, mode_now;
  logic [DW-1:0]  div_q, div_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [W-1:0]   o_q, o_d;
  logic           wrap_q, wrap_d;

  assign mode_now = MODE ? ST_SCAN : ST_DIRECT;

  always_comb begin
    idx_d  = idx_q;
    div_d  = div_q;
    wrap_d = 1'b0;
    mode_d = mode_now;
    o_d    = '0;

    if (LOAD) begin
      // LOAD wins over both the mode-change restart and the scan advance.
      idx_d = A;
      div_d = '0;
    end else if (mode_now != mode_q) begin
      // Entering or leaving scan restarts the dwell without advancing.
      div_d = '0;
    end else if (mode_now == ST_DIRECT) begin
      div_d = '0;
    end else if (E) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        idx_d  = idx_q + N'(1);
        wrap_d = (idx_q == '1);
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    o_d[idx_d] = E;

`ifdef SCAN_DECODER_BLANK_EN
    // Blank the first cycle of every dwell, including LOAD/MODE restarts.
    if ((mode_now == ST_SCAN) && (SCAN_DIV > 1) && (div_d == '0)) begin
      o_d = '0;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= ST_DIRECT;
      div_q  <= '0;
      idx_q  <= '0;
      o_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      o_q    <= o_d;
      wrap_q <= wrap_d;
    end
  end

  assign O    = o_q;
  assign IDX  = idx_q;
  assign WRAP = wrap_q;

endmodule
